// File: rtl/definitions_pkg.sv
// Shared definitions for the 9-bit processor.
// Holds the fetch sequencer state type and the default sizes of the
// program counter, the jump target table and the cycle counter.
package Definitions;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

    // Default PC / instruction ROM address width
    localparam int DEF_PC_W  = 10;
    // Default number of jump target table entries (addressed by TargSel)
    localparam int DEF_LUT_N = 8;
    // Default cycle counter width
    localparam int DEF_CNT_W = 16;
    // Width of TargSel / LutWrIdx; the table size must be 2**TSEL_W
    localparam int TSEL_W    = 3;

endpackage

// File: rtl/jump_lut.sv
// jump_lut: register-based table of branch/jump targets.
//   Clk     - rising-edge clock
//   Reset   - asynchronous active-low reset, clears every entry to 0
//   WrEn    - write strobe, WrIdx/WrData written at the clock edge
//   RdIdx   - asynchronous read index (TargSel from the decoder)
//   RdData  - current contents of the addressed entry
// A read and a write to the same entry in one cycle returns the old value,
// because the read is combinational from the registers.
module jump_lut
    import Definitions::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int LUT_N = DEF_LUT_N
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [TSEL_W-1:0] WrIdx,
    input  logic [PC_W-1:0]   WrData,
    input  logic [TSEL_W-1:0] RdIdx,
    output logic [PC_W-1:0]   RdData
);

    logic [PC_W-1:0] lut [LUT_N];

    // Table registers: cleared on reset, written by the loader in any state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (WrEn) begin
            lut[WrIdx] <= WrData;
        end
    end

    // Asynchronous read port
    assign RdData = lut[RdIdx];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer.
//   Clk, Reset      - rising-edge clock, asynchronous active-low reset
//   Start           - begin a run from PC 0 (ignored while running)
//   Jump, BranchEn, Zero, TargSel, Ack - decoder/ALU controls for the
//                     instruction currently on InstrAddr
//   LutWrEn/Idx/Data - target table write port
//   InstrAddr       - registered PC to the instruction ROM
//   Running         - high in RUN
//   Done / Fault    - halted after Ack / halted after PC overflow
//   CycleCount      - saturating count of RUN cycles of the current/last run
module fetch_unit
    import Definitions::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int LUT_N = DEF_LUT_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Jump,
    input  logic              BranchEn,
    input  logic              Zero,
    input  logic [TSEL_W-1:0] TargSel,
    input  logic              Ack,
    input  logic              LutWrEn,
    input  logic [TSEL_W-1:0] LutWrIdx,
    input  logic [PC_W-1:0]   LutWrData,
    output logic [PC_W-1:0]   InstrAddr,
    output logic              Running,
    output logic              Done,
    output logic              Fault,
    output logic [CNT_W-1:0]  CycleCount
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic            done_q, done_next;
    logic            fault_q, fault_next;
    logic [PC_W-1:0] target;

    jump_lut #(
        .PC_W  (PC_W),
        .LUT_N (LUT_N)
    ) u_lut (
        .Clk    (Clk),
        .Reset  (Reset),
        .WrEn   (LutWrEn),
        .WrIdx  (LutWrIdx),
        .WrData (LutWrData),
        .RdIdx  (TargSel),
        .RdData (target)
    );

    // State, PC, counter and halt flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            cnt     <= cnt_next;
            done_q  <= done_next;
            fault_q <= fault_next;
        end
    end

    // Next-state and next-PC selection.
    // In RUN, Ack wins over any jump/branch; a sequential step from the
    // last address halts with Fault instead of wrapping the PC to 0.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_next   = cnt;
        done_next  = done_q;
        fault_next = fault_q;
        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                    done_next  = 1'b0;
                    fault_next = 1'b0;
                end
            end
            RUN: begin
                if (cnt != {CNT_W{1'b1}}) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                if (Ack) begin
                    state_next = HALT;
                    done_next  = 1'b1;
                end else if (Jump || (BranchEn && Zero)) begin
                    pc_next = target;
                end else if (pc == {PC_W{1'b1}}) begin
                    state_next = HALT;
                    fault_next = 1'b1;
                end else begin
                    pc_next = pc + PC_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign InstrAddr  = pc;
    assign Running    = (state == RUN);
    assign Done       = done_q;
    assign Fault      = fault_q;
    assign CycleCount = cnt;

endmodule
